// File: rtl/stage_writeback_vl.sv
// Write-back stage: aligns and extends results, and stalls upstream while a load
// response from variable-latency data memory is outstanding.
module stage_writeback_vl #(
  parameter int          XLEN         = 32,
  parameter int          LOAD_TIMEOUT = 255,
  parameter int          STALL_CNT_W  = 16,
  parameter logic [31:0] NOP_PC       = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [XLEN-1:0]            dmem_read_data_i,
  input  logic                       dmem_read_valid_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                ir_i,
  input  logic                       load_i,
  input  logic [2:0]                 ma_size_i,
  input  logic [$clog2(XLEN/8)-1:0]  ma_alignment_i,
  input  logic [4:0]                 wb_addr_i,
  input  logic [XLEN-1:0]            wb_data_i,
  input  logic                       wb_valid_i,
  output logic                       empty_async_o,
  output logic [4:0]                 wb_addr_o,
  output logic [XLEN-1:0]            wb_data_o,
  output logic                       wb_valid_o,
  output logic                       load_fault_o,
  output logic [STALL_CNT_W-1:0]     stall_cycles_o
);

  localparam int AW   = $clog2(XLEN/8);
  localparam int TO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [4:0]             wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;
  logic                   wb_valid_q, wb_valid_d;
  logic                   fault_q, fault_d;
  logic [31:0]            hold_pc_q, hold_pc_d;
  logic [31:0]            hold_ir_q, hold_ir_d;
  logic [2:0]             hold_size_q, hold_size_d;
  logic [AW-1:0]          hold_align_q, hold_align_d;
  logic [4:0]             hold_addr_q, hold_addr_d;
  logic                   hold_wbv_q, hold_wbv_d;
  logic                   accept;
  logic                   unused_hold;

  // Shift the addressed bytes down, then sign/zero-extend from the access width.
  function automatic logic [XLEN-1:0] align_extend(input logic [XLEN-1:0] raw,
                                                   input logic [AW-1:0]   align,
                                                   input logic [2:0]      size);
    logic [XLEN-1:0]        shifted;
    logic [XLEN-1:0]        tmp;
    logic signed [XLEN-1:0] stmp;
    int                     n;
    int                     sh;
    logic                   sgn;
    shifted = raw >> {align, 3'b000};
    case (size)
      3'b000:  begin n = 8;  sgn = 1'b1; end
      3'b001:  begin n = 16; sgn = 1'b1; end
      3'b010:  begin n = 32; sgn = 1'b1; end
      3'b100:  begin n = 8;  sgn = 1'b0; end
      3'b101:  begin n = 16; sgn = 1'b0; end
      3'b110:  begin n = 32; sgn = 1'b0; end
      default: begin n = XLEN; sgn = 1'b0; end
    endcase
    sh   = XLEN - n;
    tmp  = shifted << sh;
    stmp = tmp;
    if (sgn) align_extend = stmp >>> sh;
    else     align_extend = tmp >> sh;
  endfunction

  assign ready_o       = (state_q == S_IDLE);
  assign accept        = valid_i & ready_o;
  assign empty_async_o = (state_q == S_IDLE) & (~valid_i | (pc_i == NOP_PC));

  assign wb_addr_o      = wb_addr_q;
  assign wb_data_o      = wb_data_q;
  assign wb_valid_o     = wb_valid_q;
  assign load_fault_o   = fault_q;
  assign stall_cycles_o = stall_q;

  // pc/ir are held for debug visibility only; nothing downstream consumes them.
  assign unused_hold = ^{hold_pc_q, hold_ir_q};

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_valid_d   = 1'b0;
    fault_d      = 1'b0;
    hold_pc_d    = hold_pc_q;
    hold_ir_d    = hold_ir_q;
    hold_size_d  = hold_size_q;
    hold_align_d = hold_align_q;
    hold_addr_d  = hold_addr_q;
    hold_wbv_d   = hold_wbv_q;
    stall_d      = stall_q;

    if (!ready_o && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!load_i || dmem_read_valid_i) begin
            wb_data_d  = align_extend(load_i ? dmem_read_data_i : wb_data_i,
                                      ma_alignment_i, ma_size_i);
            wb_addr_d  = wb_addr_i;
            wb_valid_d = wb_valid_i & (wb_addr_i != 5'd0);
          end else begin
            hold_pc_d    = pc_i;
            hold_ir_d    = ir_i;
            hold_size_d  = ma_size_i;
            hold_align_d = ma_alignment_i;
            hold_addr_d  = wb_addr_i;
            hold_wbv_d   = wb_valid_i;
            to_cnt_d     = '0;
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_read_valid_i) begin
          wb_data_d  = align_extend(dmem_read_data_i, hold_align_q, hold_size_q);
          wb_addr_d  = hold_addr_q;
          wb_valid_d = hold_wbv_q & (hold_addr_q != 5'd0);
          state_d    = S_IDLE;
        end else if ((LOAD_TIMEOUT != 0) && (to_cnt_q == TO_W'(LOAD_TIMEOUT - 1))) begin
          // This cycle would bring the count to the limit: give up on the load.
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      to_cnt_q     <= '0;
      stall_q      <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      hold_pc_q    <= '0;
      hold_ir_q    <= '0;
      hold_size_q  <= '0;
      hold_align_q <= '0;
      hold_addr_q  <= '0;
      hold_wbv_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      stall_q      <= stall_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_valid_q   <= wb_valid_d;
      fault_q      <= fault_d;
      hold_pc_q    <= hold_pc_d;
      hold_ir_q    <= hold_ir_d;
      hold_size_q  <= hold_size_d;
      hold_align_q <= hold_align_d;
      hold_addr_q  <= hold_addr_d;
      hold_wbv_q   <= hold_wbv_d;
    end
  end

endmodule

// File: tb/tb_stage_writeback_vl.sv
// Scoreboard bench: three instances (32-bit, 32-bit short timeout, 64-bit) driven
// one at a time; a negedge monitor pops expected write-backs/faults as they appear.
module tb_stage_writeback_vl;

  typedef struct {
    int          inst;
    bit          fault;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] dmem_data = '0;
  logic        dmem_valid = 1'b0;
  logic [2:0]  v_sel = '0;
  logic [31:0] pc = '0;
  logic [31:0] ir = 32'h0000_0013;
  logic        load = 1'b0;
  logic [2:0]  size = '0;
  logic [2:0]  align = '0;
  logic [4:0]  wb_addr = '0;
  logic [63:0] wb_data = '0;
  logic        wb_valid_in = 1'b0;

  logic        ready_a, empty_a, wbv_a, fault_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  logic [15:0] stall_a;
  logic        ready_t, empty_t, wbv_t, fault_t;
  logic [4:0]  addr_t;
  logic [31:0] data_t;
  logic [15:0] stall_t;
  logic        ready_w, empty_w, wbv_w, fault_w;
  logic [4:0]  addr_w;
  logic [63:0] data_w;
  logic [15:0] stall_w;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stage_writeback_vl #(.XLEN(32), .LOAD_TIMEOUT(255), .STALL_CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .dmem_read_data_i(dmem_data[31:0]), .dmem_read_valid_i(dmem_valid),
    .valid_i(v_sel[0]), .ready_o(ready_a), .pc_i(pc), .ir_i(ir), .load_i(load),
    .ma_size_i(size), .ma_alignment_i(align[1:0]), .wb_addr_i(wb_addr), .wb_data_i(wb_data[31:0]),
    .wb_valid_i(wb_valid_in), .empty_async_o(empty_a), .wb_addr_o(addr_a), .wb_data_o(data_a),
    .wb_valid_o(wbv_a), .load_fault_o(fault_a), .stall_cycles_o(stall_a));

  stage_writeback_vl #(.XLEN(32), .LOAD_TIMEOUT(3), .STALL_CNT_W(16)) u_t (
    .clk_i(clk), .rst_i(rst), .dmem_read_data_i(dmem_data[31:0]), .dmem_read_valid_i(dmem_valid),
    .valid_i(v_sel[1]), .ready_o(ready_t), .pc_i(pc), .ir_i(ir), .load_i(load),
    .ma_size_i(size), .ma_alignment_i(align[1:0]), .wb_addr_i(wb_addr), .wb_data_i(wb_data[31:0]),
    .wb_valid_i(wb_valid_in), .empty_async_o(empty_t), .wb_addr_o(addr_t), .wb_data_o(data_t),
    .wb_valid_o(wbv_t), .load_fault_o(fault_t), .stall_cycles_o(stall_t));

  stage_writeback_vl #(.XLEN(64), .LOAD_TIMEOUT(255), .STALL_CNT_W(16)) u_w (
    .clk_i(clk), .rst_i(rst), .dmem_read_data_i(dmem_data), .dmem_read_valid_i(dmem_valid),
    .valid_i(v_sel[2]), .ready_o(ready_w), .pc_i(pc), .ir_i(ir), .load_i(load),
    .ma_size_i(size), .ma_alignment_i(align), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .wb_valid_i(wb_valid_in), .empty_async_o(empty_w), .wb_addr_o(addr_w), .wb_data_o(data_w),
    .wb_valid_o(wbv_w), .load_fault_o(fault_w), .stall_cycles_o(stall_w));

  logic [2:0]  o_v;
  logic [2:0]  o_f;
  logic [4:0]  o_addr [3];
  logic [63:0] o_data [3];
  assign o_v       = {wbv_w, wbv_t, wbv_a};
  assign o_f       = {fault_w, fault_t, fault_a};
  assign o_addr[0] = addr_a;
  assign o_addr[1] = addr_t;
  assign o_addr[2] = addr_w;
  assign o_data[0] = {32'h0, data_a};
  assign o_data[1] = {32'h0, data_t};
  assign o_data[2] = data_w;

  // Monitor: every write-back or fault pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (o_v[i] || o_f[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out inst %0d got v=%0b f=%0b addr=%0d data=%h want nothing",
                     i, o_v[i], o_f[i], o_addr[i], o_data[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != i || e.fault != o_f[i] ||
                (e.fault ? o_v[i] : (!o_v[i] || o_addr[i] != e.addr || o_data[i] != e.data))) begin
              errors++;
              $display("FAIL wb_out inst %0d got v=%0b f=%0b addr=%0d data=%h want inst %0d f=%0b addr=%0d data=%h",
                       i, o_v[i], o_f[i], o_addr[i], o_data[i], e.inst, e.fault, e.addr, e.data);
            end else begin
              $display("ok   inst %0d f=%0b addr=%0d data=%h", i, o_f[i], o_addr[i], o_data[i]);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic exp_wr(input int inst, input logic [4:0] a, input logic [63:0] d);
    exp_q.push_back('{inst: inst, fault: 1'b0, addr: a, data: d});
  endtask

  task automatic exp_fault(input int inst);
    exp_q.push_back('{inst: inst, fault: 1'b1, addr: 5'd0, data: 64'h0});
  endtask

  // Present one instruction to instance `inst` for exactly one clock edge.
  task automatic issue(input int inst, input logic ld, input logic [2:0] sz, input logic [2:0] al,
                       input logic [4:0] ad, input logic [63:0] d, input logic dv,
                       input logic [63:0] dm);
    load        = ld;
    size        = sz;
    align       = al;
    wb_addr     = ad;
    wb_data     = d;
    wb_valid_in = 1'b1;
    dmem_valid  = dv;
    dmem_data   = dm;
    pc          = 32'h0000_0100;
    v_sel       = 3'(1 << inst);
    @(posedge clk); #1;
    v_sel       = '0;
    dmem_valid  = 1'b0;
    wb_valid_in = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_wbv_a",   64'(wbv_a),   64'h0);
    chk("rst_addr_a",  64'(addr_a),  64'h0);
    chk("rst_data_a",  64'(data_a),  64'h0);
    chk("rst_fault_t", 64'(fault_t), 64'h0);
    chk("rst_stall_a", 64'(stall_a), 64'h0);
    chk("rst_ready_w", 64'(ready_w), 64'h1);
    chk("rst_data_w",  64'(data_w),  64'h0);
    chk("empty_idle",  64'(empty_a), 64'h1);
    v_sel = 3'b001; pc = 32'h0000_0100; #1;
    chk("empty_live",  64'(empty_a), 64'h0);
    pc = 32'h0000_0000; #1;
    chk("empty_nop",   64'(empty_a), 64'h1);
    v_sel = '0;
    @(posedge clk); #1;

    exp_wr(0, 5'd5, 64'h1234_5678);
    issue(0, 1'b0, 3'b010, 3'd0, 5'd5, 64'h1234_5678, 1'b0, 64'h0);
    exp_wr(0, 5'd6, 64'hFFFF_FF80);
    issue(0, 1'b1, 3'b000, 3'd3, 5'd6, 64'h0, 1'b1, 64'h80AA_BBCC);
    exp_wr(0, 5'd7, 64'h0000_0080);
    issue(0, 1'b1, 3'b100, 3'd3, 5'd7, 64'h0, 1'b1, 64'h80AA_BBCC);
    exp_wr(0, 5'd8, 64'h0080_AABB);
    issue(0, 1'b1, 3'b111, 3'd1, 5'd8, 64'h0, 1'b1, 64'h80AA_BBCC);

    issue(0, 1'b0, 3'b010, 3'd0, 5'd0, 64'hDEAD_BEEF, 1'b0, 64'h0);
    chk("x0_wbv",  64'(wbv_a),  64'h0);
    chk("x0_data", 64'(data_a), 64'hDEAD_BEEF);
    chk("x0_addr", 64'(addr_a), 64'h0);

    exp_wr(0, 5'd9, 64'hFFFF_8001);
    issue(0, 1'b1, 3'b001, 3'd0, 5'd9, 64'h0, 1'b0, 64'h0000_8001);
    for (int k = 0; k < 4; k++) begin
      chk("late_ready_low", 64'(ready_a), 64'h0);
      if (k == 3) dmem_valid = 1'b1;
      @(posedge clk); #1;
      dmem_valid = 1'b0;
    end
    chk("late_ready_back", 64'(ready_a), 64'h1);
    chk("late_stall_cnt",  64'(stall_a), 64'd4);

    exp_fault(1);
    issue(1, 1'b1, 3'b010, 3'd0, 5'd10, 64'h0, 1'b0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      chk("to_ready_low", 64'(ready_t), 64'h0);
      @(posedge clk); #1;
    end
    chk("to_fault_pulse", 64'(fault_t), 64'h1);
    chk("to_ready_back",  64'(ready_t), 64'h1);
    @(posedge clk); #1;
    chk("to_fault_once",  64'(fault_t), 64'h0);

    exp_wr(1, 5'd11, 64'h1357_9BDF);
    issue(1, 1'b1, 3'b010, 3'd0, 5'd11, 64'h0, 1'b0, 64'h1357_9BDF);
    repeat (2) @(posedge clk);
    #1 dmem_valid = 1'b1;
    @(posedge clk); #1;
    dmem_valid = 1'b0;
    chk("race_no_fault", 64'(fault_t), 64'h0);

    exp_wr(2, 5'd12, 64'h8000_0000_0000_0001);
    issue(2, 1'b1, 3'b011, 3'd0, 5'd12, 64'h0, 1'b1, 64'h8000_0000_0000_0001);
    exp_wr(2, 5'd13, 64'h0000_0000_8000_0000);
    issue(2, 1'b1, 3'b110, 3'd4, 5'd13, 64'h0, 1'b1, 64'h8000_0000_0000_0001);
    exp_wr(2, 5'd14, 64'hFFFF_FFFF_8000_0000);
    issue(2, 1'b1, 3'b010, 3'd4, 5'd14, 64'h0, 1'b1, 64'h8000_0000_0000_0001);
    exp_wr(2, 5'd15, 64'h0000_0000_0000_8000);
    issue(2, 1'b1, 3'b101, 3'd6, 5'd15, 64'h0, 1'b1, 64'h8000_0000_0000_0001);

    issue(0, 1'b1, 3'b010, 3'd0, 5'd16, 64'h0, 1'b0, 64'h0000_1234);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_valid = 1'b1;
    @(posedge clk); #1;
    dmem_valid = 1'b0;
    chk("rstwait_wbv",   64'(wbv_a),   64'h0);
    chk("rstwait_addr",  64'(addr_a),  64'h0);
    chk("rstwait_data",  64'(data_a),  64'h0);
    chk("rstwait_fault", 64'(fault_a), 64'h0);
    chk("rstwait_ready", 64'(ready_a), 64'h1);
    chk("rstwait_stall", 64'(stall_a), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_expect", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
